// File: rtl/gauss_conv1d_stream.sv
`default_nettype none
// ============================================================================
// Module   : gauss_conv1d_stream
// Brief    : Streaming 1-D Gaussian convolution over pixel lines with
//            edge-replicated borders, round-to-nearest with saturation, a
//            per-line latched sigma and valid/ready backpressure on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module gauss_conv1d_stream #(
  parameter int DATA_W = 8,
  parameter int RADIUS = 5,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sigma,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int TAPS   = 2*RADIUS+1;
  localparam int PROD_W = DATA_W+COEF_W;
  localparam int SUM_W  = DATA_W+COEF_W+4;
  localparam int POS_W  = $clog2(RADIUS+1);
  // The built-in table is stored at 2^8 scale and rescaled to COEF_W
  localparam int SH_L   = (COEF_W >= 8) ? COEF_W-8 : 0;
  localparam int SH_R   = (COEF_W < 8)  ? 8-COEF_W : 0;

  localparam logic [POS_W-1:0] c_POS_MAX = POS_W'(RADIUS);
  localparam logic [POS_W-1:0] c_POS_ISS = POS_W'(RADIUS-1);
  localparam logic [POS_W-1:0] c_FL_LAST = POS_W'(RADIUS-1);
  localparam logic [SUM_W-1:0] c_HALF    = SUM_W'(1) << (COEF_W-1);
  localparam logic [SUM_W-1:0] c_PIX_MAX = SUM_W'({DATA_W{1'b1}});

  // One 48-bit row per sigma, |k|=0 in the low byte up to |k|=5
  localparam logic [8*48-1:0] c_TAB = {
    48'h1113_161a_1d1e,   // sigma 7
    48'h0d10_161c_2022,   // sigma 6
    48'h080c_141e_2629,   // sigma 5
    48'h0307_111f_2d33,   // sigma 4
    48'h0002_091c_3744,   // sigma 3
    48'h0000_010e_3e66,   // sigma 2
    48'h0000_0000_1bca,   // sigma 1
    48'h0000_0000_0000    // sigma 0 handled separately (exact 1.0 centre)
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [COEF_W:0] coef_lookup(input logic [2:0] sg, input int ak);
    logic [7:0]  c8;
    int unsigned v;
    c8 = 8'd0;
    v  = 0;
    if (sg == 3'd0) begin
      v = (ak == 0) ? 32'd256 : 32'd0;
    end else if (ak <= 5) begin
      c8 = c_TAB[(int'(sg)*6 + ak)*8 +: 8];
      v  = 32'(c8);
    end
    v = (v << SH_L) >> SH_R;
    return v[COEF_W:0];
  endfunction

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_win [TAPS];
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    r_fcnt;
  logic [2:0]          r_sig;
  logic                r_w_valid, r_w_last;
  logic                r_busy;

  logic [PROD_W-1:0]   r_s1_prod [TAPS];
  logic                r_s1_valid, r_s1_last;
  logic [SUM_W-1:0]    r_s2_sum;
  logic                r_s2_valid, r_s2_last;
  logic [DATA_W-1:0]   r_s3_data;
  logic                r_s3_valid, r_s3_last;

  logic                w_adv, w_acc;
  logic                w_fill, w_shift, w_issue, w_issue_last;
  logic [DATA_W-1:0]   w_new;
  logic [COEF_W:0]     w_coef [TAPS];
  logic [PROD_W-1:0]   w_prod [TAPS];
  logic [SUM_W-1:0]    w_sum, w_rnd, w_y;
  logic [DATA_W-1:0]   w_sat;

  // Whole pipeline freezes only while a presented output is refused
  assign w_adv   = !(r_s3_valid && !m_ready);
  assign s_ready = w_adv && (r_state != ST_FLUSH) && !reset;
  assign w_acc   = s_valid && s_ready;

  // Next state plus window shift/issue controls
  always_comb begin
    w_state_nxt  = r_state;
    w_fill       = 1'b0;
    w_shift      = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_new        = s_data;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_fill      = 1'b1;
          w_state_nxt = s_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          w_shift = 1'b1;
          w_issue = (r_pos >= c_POS_ISS);
          if (s_last) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_adv) begin
          w_shift = 1'b1;
          w_new   = r_win[TAPS-1];       // replicate the final pixel
          w_issue = (r_pos >= c_POS_ISS);
          if (r_fcnt == c_FL_LAST) begin
            w_issue_last = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Window: first pixel of a line replicates into every slot, then shifts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < TAPS; p++) r_win[p] <= '0;
    end else if (w_fill) begin
      for (int p = 0; p < TAPS; p++) r_win[p] <= s_data;
    end else if (w_shift) begin
      for (int p = 0; p < TAPS-1; p++) r_win[p] <= r_win[p+1];
      r_win[TAPS-1] <= w_new;
    end
  end

  // Line control: state, fill position, flush count, sigma latch, busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pos     <= '0;
      r_fcnt    <= '0;
      r_sig     <= 3'd0;
      r_w_valid <= 1'b0;
      r_w_last  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fill) begin
        r_pos <= '0;
        r_sig <= sigma;
      end else if (w_shift && (r_pos != c_POS_MAX)) begin
        r_pos <= r_pos + 1'b1;
      end
      if (r_state != ST_FLUSH) r_fcnt <= '0;
      else if (w_adv)          r_fcnt <= r_fcnt + 1'b1;
      if (w_adv) begin
        r_w_valid <= w_issue;
        r_w_last  <= w_issue_last;
      end
      if (w_acc && (r_state == ST_IDLE))          r_busy <= 1'b1;
      else if (r_s3_valid && m_ready && r_s3_last) r_busy <= 1'b0;
    end
  end

  // Per-tap coefficient and product; |k| folds the symmetric kernel
  always_comb begin
    for (int p = 0; p < TAPS; p++) begin
      w_coef[p] = coef_lookup(r_sig, (p >= RADIUS) ? (p - RADIUS) : (RADIUS - p));
      w_prod[p] = PROD_W'(r_win[p]) * PROD_W'(w_coef[p]);
    end
  end

  // Adder tree over the registered products
  always_comb begin
    w_sum = '0;
    for (int p = 0; p < TAPS; p++) w_sum = w_sum + SUM_W'(r_s1_prod[p]);
  end

  assign w_rnd = r_s2_sum + c_HALF;
  assign w_y   = w_rnd >> COEF_W;
  assign w_sat = (w_y > c_PIX_MAX) ? {DATA_W{1'b1}} : w_y[DATA_W-1:0];

  // Arithmetic pipeline: products -> sum -> round/saturate output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < TAPS; p++) r_s1_prod[p] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s3_data  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
    end else if (w_adv) begin
      for (int p = 0; p < TAPS; p++) r_s1_prod[p] <= w_prod[p];
      r_s1_valid <= r_w_valid;
      r_s1_last  <= r_w_last;
      r_s2_sum   <= w_sum;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s3_data  <= w_sat;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
    end
  end

  assign m_valid = r_s3_valid;
  assign m_data  = r_s3_data;
  assign m_last  = r_s3_last;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: doc/gauss_conv1d_stream.md
Name: gauss_conv1d_stream

Overview:
Streaming, pipelined 1-D Gaussian convolution over pixel lines, using valid/ready handshakes on both input and output.
- Generalises the combinational 11-tap dot product to a parametrised radius and data width.
- Adds edge-replicating line borders, round-to-nearest with saturation, a per-line latched sigma, and backpressure.
- Sits between the line-buffer/DMA reader and the transpose stage; the same instance serves horizontal and vertical passes.

Parameters:
DATA_W, 8, pixel width in bits.
RADIUS, 5, kernel half-width; TAPS = 2*RADIUS+1. Legal range 5..7. Taps with |k|>5 use coefficient 0.
COEF_W, 8, coefficient width. Coefficients are unsigned fractions scaled by 2^COEF_W.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
sigma  in  3  kernel select: 0 = passthrough, 1..7 = built-in Gaussian table. Sampled per line.
s_valid  in  1  input pixel valid.
s_ready  out  1  block accepts the input pixel this cycle.
s_data  in  DATA_W  input pixel.
s_last  in  1  marks the final pixel of a line.
m_valid  out  1  output pixel valid.
m_ready  in  1  downstream accepts the output pixel.
m_data  out  DATA_W  filtered pixel.
m_last  out  1  marks the final output pixel of a line.
busy  out  1  high from the first accepted beat of a line until its last output is accepted.

Behaviour:
- Reset (async assert, sync release): s_ready=0 during reset and 1 in the first cycle after release. m_valid=0, m_data=0, m_last=0, busy=0. State=IDLE; window and pipeline contents are cleared. Reset mid-line discards all in-flight data; no partial line is emitted.
- Beat transfer: a beat moves when valid&&ready. Once m_valid is asserted, m_valid, m_data and m_last hold stable until m_ready.
- Stall rule: the whole pipeline advances only when !(m_valid && !m_ready). s_ready = advance && state!=FLUSH.
- sigma: latched into an internal register on the first accepted beat of each line (state IDLE). Changes mid-line are ignored.
- Coefficient table: symmetric, indexed by sigma and |k|. Values for k=0..5:
  - sigma1: ca,1b,00,00,00,00
  - sigma2: 66,3e,0e,01,00,00
  - sigma3: 44,37,1c,09,02,00
  - sigma4: 33,2d,1f,11,07,03
  - sigma5: 29,26,1e,14,0c,08
  - sigma6: 22,20,1c,16,10,0d
  - sigma7: 1e,1d,1a,16,13,11
  - sigma0: center coefficient 1.0 exactly, i.e. passthrough, no rounding.
- Border handling: for a line x[0..N-1], out[i] = sum over k of c[k]*x[clamp(i+k, 0, N-1)]. Exactly N outputs per line; m_last is on out[N-1].
- State machine:
  - IDLE: on the first accepted beat, fill every window slot at or left of centre with x[0], latch sigma, go to RUN. If s_last is also set (N=1), go to FLUSH instead.
  - RUN: each accepted beat shifts into the window. Output out[j-RADIUS] is issued once j>=RADIUS. An accepted beat with s_last goes to FLUSH.
  - FLUSH: s_ready=0. Shift in the replicated x[N-1] for RADIUS advancing cycles, issuing the remaining outputs. Then go to IDLE. Lines with N<=RADIUS work the same way: an out[] index below 0 is never issued.
- Pipeline: window issue -> S1 (TAPS products, DATA_W+COEF_W bits) -> S2 (adder tree, DATA_W+COEF_W+4 bits) -> S3 (round and saturate) -> output register.
  - Latency is 3 advancing cycles from issue to m_valid.
  - Each stage carries its own valid and last flags.
- Arithmetic: y = (sum + 2^(COEF_W-1)) >> COEF_W. If y > 2^DATA_W-1, output 2^DATA_W-1.
- busy falls in the cycle after the m_last beat transfers.
- Throughput: 1 pixel/cycle in RUN with no backpressure, plus a RADIUS-cycle flush bubble per line.

Test Plan:
1. sigma=0, line 10,20,30,40 (N=4), m_ready=1 -> outputs 10,20,30,40. m_last on the 4th beat; first m_valid 3 cycles after the RADIUS-th issue.
2. sigma=3, 16-pixel line, all pixels 100 -> 16 outputs, all 100 (kernel sum is 256 exactly).
3. sigma=1, 16 zeros with x[8]=200 -> out[7]=21, out[8]=158, out[9]=21, all others 0.
4. sigma=4, constant 255 line (kernel sum 257) -> every output saturates to 255, no wrap to 0.
5. sigma=2, N=1 pixel 77 with s_last on the same beat -> exactly one output; m_data=77 (0x100*77 rounded), m_last=1, busy then low.
6. Random m_ready at 50% duty over a 64-pixel random line, with sigma toggled mid-line and reset asserted mid-second-line:
   - output matches the golden model using the sigma latched on beat 0;
   - m_data is stable while stalled;
   - after reset, m_valid=0 and a new line processes cleanly.
